// File: rtl/byte_lane_loader_pkg.sv
// Shared definitions for the byte lane loader: FSM state encoding and
// lane geometry used by the loader and anything that consumes its lanes.
package byte_lane_loader_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int HOLD_W    = 4;

endpackage

// File: rtl/byte_lane_loader.sv
// Byte lane loader: collects four bytes into a lane register array, then
// walks a 2-bit select across the lanes (each value held EMIT_HOLD cycles)
// to drive a downstream 4:1 sign-extending mux.
// Optional feature: define FRAME_CNT_EN to add the 8-bit frame_count output.
module byte_lane_loader
    import byte_lane_loader_pkg::*;
#(
    parameter int EMIT_HOLD = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] lane0,
    output logic [LANE_W-1:0] lane1,
    output logic [LANE_W-1:0] lane2,
    output logic [LANE_W-1:0] lane3,
    output logic [1:0]        select,
    output logic              sel_valid,
`ifdef FRAME_CNT_EN
    output logic [7:0]        frame_count,
`endif
    output logic              frame_done
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EMIT_HOLD - 1);

    state_t              state;
    state_t              state_next;
    logic [1:0]          byte_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [LANE_W-1:0]   lanes [NUM_LANES];
    logic                accept;
    logic                last_step;

    assign accept = in_valid && in_ready;

    // State register; reset and flush both return the loader to LOAD.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode, all outputs derived from registered state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        sel_valid  = 1'b0;
        last_step  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == 2'd3) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                sel_valid = 1'b1;
                if (select == 2'd3 && hold_cnt == HOLD_LAST) begin
                    last_step  = 1'b1;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
        frame_done = last_step && reset_n && !flush;
    end

    // Lane fill, byte counter and select/hold sequencing. byte_cnt and
    // select both wrap to 0 naturally at the end of their sweeps.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            byte_cnt <= '0;
            select   <= '0;
            hold_cnt <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            if (accept) begin
                lanes[byte_cnt] <= in_data;
                byte_cnt        <= byte_cnt + 2'd1;
            end
            if (state == EMIT) begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt <= '0;
                    select   <= select + 2'd1;
                end else begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end
        end
    end

`ifdef FRAME_CNT_EN
    // Completed-frame counter, wraps naturally at 255.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            frame_count <= '0;
        end else if (frame_done) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

    assign lane0 = lanes[0];
    assign lane1 = lanes[1];
    assign lane2 = lanes[2];
    assign lane3 = lanes[3];

endmodule

// File: doc/byte_lane_loader.md
BYTE_LANE_LOADER -- requirements
Module: byte_lane_loader

Interface
REQ-001 SHALL provide parameter EMIT_HOLD, default 1, giving the clock cycles each select value is held in EMIT (legal 1..15).
REQ-002 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset; synchronous and active-low.
REQ-004 SHALL have port flush, input, 1, synchronous frame abort.
REQ-005 SHALL have port in_data, input, 8, the incoming byte.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid.
REQ-007 SHALL have port in_ready, output, 1, the loader accepts a byte this cycle.
REQ-008 SHALL have ports lane0, lane1, lane2, lane3, output, 8 each, the registered byte lanes feeding the downstream 4:1 sign-extending mux inputs i0..i3.
REQ-009 SHALL have port select, output, 2, the lane index driving the mux select.
REQ-010 SHALL have port sel_valid, output, 1, select and lanes form a valid mux request this cycle.
REQ-011 SHALL have port frame_done, output, 1, a one-cycle pulse when the last select step of a frame completes.

Function
REQ-012 SHALL implement a two-state FSM: LOAD and EMIT.
REQ-013 In LOAD, in_ready SHALL be 1 and sel_valid 0; in_ready is decoded from registered state only.
REQ-014 Each LOAD handshake (in_valid and in_ready) SHALL write in_data into lane[byte_cnt] and increment the 2-bit byte_cnt; the first byte goes to lane0.
REQ-015 The handshake that fills lane3 SHALL move the FSM to EMIT next cycle with select=0, sel_valid=1, and the hold counter cleared.
REQ-016 In EMIT, in_ready SHALL be 0; any in_valid byte is neither consumed nor written.
REQ-017 In EMIT, select SHALL stay stable for exactly EMIT_HOLD cycles, then increment; lanes SHALL not change during EMIT.
REQ-018 After select=3 has been held EMIT_HOLD cycles, frame_done SHALL pulse for one cycle and the FSM SHALL return to LOAD with byte_cnt=0, select=0, and sel_valid=0 in the same cycle.
REQ-019 Lane contents SHALL persist into the next LOAD until overwritten byte by byte.
REQ-020 With EMIT_HOLD=1, a frame SHALL take 4 handshake cycles plus 4 EMIT cycles; back-to-back frames are allowed without idle cycles.
REQ-021 In LOAD, in_valid=0 SHALL stall with no state change; gaps between bytes are allowed.
REQ-022 flush=1 SHALL, on that edge and in any state, force LOAD, byte_cnt=0, select=0, hold counter=0, and clear all lanes to 0; frame_done SHALL not pulse.
REQ-023 Simultaneous flush and a LOAD handshake SHALL drop the byte (flush wins).

Reset
REQ-024 reset_n=0 at a rising edge SHALL set state=LOAD, byte_cnt=0, select=0, hold counter=0, lane0..lane3=0, sel_valid=0, and frame_done=0; reset overrides flush.
REQ-025 Reset asserted mid-EMIT or mid-LOAD SHALL discard the partial frame with no frame_done.

Configuration
REQ-026 Macro FRAME_CNT_EN defined SHALL add output frame_count [7:0], reset/flush to 0, incremented on each frame_done and wrapping 255->0.
REQ-027 Without FRAME_CNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-028 A shared package SHALL hold the state enum (LOAD, EMIT), LANE_W=8, and NUM_LANES=4.
REQ-029 The design SHALL be a single module with no sub-module; the lanes are a 4-entry register array.

Verification
REQ-030 Reset, then bytes 0x11,0x82,0x33,0xF4 with EMIT_HOLD=1 -> lanes 0x11/0x82/0x33/0xF4; select 0,1,2,3 on 4 consecutive sel_valid cycles; frame_done on the 4th.
REQ-031 EMIT_HOLD=3, same frame -> each select value held 3 cycles (12 sel_valid cycles); frame_done once; in_ready=0 throughout EMIT.
REQ-032 in_valid held high with 8 bytes 0x01..0x08 -> 0x05..0x08 accepted only after frame_done; second frame lanes 0x05..0x08.
REQ-033 flush together with the third byte -> that byte dropped; lanes all 0; next 4 bytes load from lane0; no frame_done for the aborted frame.
REQ-034 reset_n=0 during EMIT at select=2 -> next cycle all outputs 0, state LOAD, in_ready=1.
REQ-035 FRAME_CNT_EN, 257 frames -> frame_count reads 1.
